// File: rtl/xoodyak_msg_streamer.sv
// xoodyak_msg_streamer: reads a message from byte RAM, streams it into XOODYAK, pulses start
// and collects the byte-serial hash into a left-justified digest register.
module xoodyak_msg_streamer #(
  parameter int ADDR_W      = 12,
  parameter int GAP_CYC     = 5,
  parameter int HASH_BYTES  = 32,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_start,
  input  logic [ADDR_W-1:0]       cmd_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [8*HASH_BYTES-1:0] digest,
  output logic [7:0]              digest_len,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [7:0]              mem_rdata,
  output logic                    x_load,
  output logic [7:0]              x_msg,
  output logic [ADDR_W-1:0]       x_msg_len,
  output logic                    x_start,
  input  logic [7:0]              x_hash,
  input  logic [7:0]              x_hash_len,
  input  logic                    x_valid
);
  localparam int DW = 8 * HASH_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, LOAD, GAP, START, WAIT_HASH} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [7:0]        hlen_q, hlen_d, rcv_q, rcv_d, dlen_q, dlen_d, lat_len;
  logic [DW-1:0]     dig_q, dig_d;
  logic              done_q, done_d, err_q, err_d, load_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      tmr_q   <= '0;
      hlen_q  <= '0;
      rcv_q   <= '0;
      dlen_q  <= '0;
      dig_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      tmr_q   <= tmr_d;
      hlen_q  <= hlen_d;
      rcv_q   <= rcv_d;
      dlen_q  <= dlen_d;
      dig_q   <= dig_d;
      done_q  <= done_d;
      err_q   <= err_d;
      load_q  <= mem_rd_en;
    end
  end
  // the hash length is taken from the first valid byte; later bytes reuse the latched value
  assign lat_len = (rcv_q != 8'd0) ? hlen_q :
                   (x_hash_len == 8'd0 || x_hash_len > 8'(HASH_BYTES)) ? 8'(HASH_BYTES) : x_hash_len;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    tmr_d   = tmr_q;
    hlen_d  = hlen_q;
    rcv_d   = rcv_q;
    dlen_d  = dlen_q;
    dig_d   = dig_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start && cmd_len == '0) err_d = 1'b1;
        else if (cmd_start) begin
          state_d = LOAD;
          len_d   = cmd_len;
          cnt_d   = '0;
          dig_d   = '0;
          dlen_d  = '0;
          rcv_d   = '0;
          hlen_d  = '0;
        end
      end
      // reads occupy cnt 0..len-1; cnt==len is the cycle carrying the last byte to x_load
      LOAD: begin
        cnt_d   = (cnt_q == len_q) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == len_q) ? GAP : LOAD;
      end
      GAP: begin
        cnt_d   = (cnt_q == ADDR_W'(GAP_CYC - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == ADDR_W'(GAP_CYC - 1)) ? START : GAP;
      end
      START: begin
        state_d = WAIT_HASH;
        tmr_d   = TW'(1);
      end
      WAIT_HASH: begin
        tmr_d = tmr_q + 1'b1;
        if (x_valid) begin
          rcv_d  = rcv_q + 8'd1;
          hlen_d = lat_len;
          dig_d  = {dig_q[DW-9:0], x_hash};
        end
        if (x_valid && rcv_d == lat_len) begin
          done_d  = 1'b1;
          state_d = IDLE;
          dlen_d  = rcv_d;
          dig_d   = dig_d << {8'(HASH_BYTES) - rcv_d, 3'b000};
        end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
          dlen_d  = rcv_q;
          dig_d   = dig_q << {8'(HASH_BYTES) - rcv_q, 3'b000};
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign mem_rd_en  = (state_q == LOAD) && (cnt_q < len_q);
  assign mem_addr   = mem_rd_en ? cnt_q : '0;
  assign busy       = state_q != IDLE;
  assign x_start    = state_q == START;
  assign x_load     = load_q;
  assign x_msg      = load_q ? mem_rdata : 8'd0;
  assign x_msg_len  = busy ? len_q : '0;
  assign done       = done_q;
  assign err        = err_q;
  assign digest     = dig_q;
  assign digest_len = dlen_q;
endmodule

// File: tb/tb_xoodyak_msg_streamer.sv
// tb_xoodyak_msg_streamer: directed scenarios with a byte-RAM model and a hand-driven hash source.
module tb_xoodyak_msg_streamer;
  logic         clk = 1'b0, resetn = 1'b0, cmd_start = 1'b0;
  logic [11:0]  cmd_len = '0;
  logic         busy, done, err, mem_rd_en, x_load, x_start;
  logic [255:0] digest;
  logic [7:0]   digest_len, x_msg;
  logic [11:0]  mem_addr, x_msg_len;
  logic [7:0]   mem_rdata = '0, x_hash = '0, x_hash_len = '0;
  logic         x_valid = 1'b0;
  logic [7:0]   ram [4096];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int load_cnt, first_load, last_load, rd_cnt, last_addr, xstart_cnt, xstart_cyc;
  int done_cnt, done_cyc, err_cnt, err_cyc, busy_cnt, both_cnt = 0, acc, last_vcyc;
  logic [7:0] loads [$];

  xoodyak_msg_streamer dut (
    .clk(clk), .resetn(resetn), .cmd_start(cmd_start), .cmd_len(cmd_len), .busy(busy),
    .done(done), .err(err), .digest(digest), .digest_len(digest_len), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .x_load(x_load), .x_msg(x_msg),
    .x_msg_len(x_msg_len), .x_start(x_start), .x_hash(x_hash), .x_hash_len(x_hash_len),
    .x_valid(x_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  always @(negedge clk) begin
    if (x_load) begin
      if (load_cnt == 0) first_load = cyc;
      last_load = cyc;
      load_cnt++;
      loads.push_back(x_msg);
    end
    if (mem_rd_en) begin rd_cnt++; last_addr = int'(mem_addr); end
    if (x_start) begin xstart_cnt++; xstart_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (busy) busy_cnt++;
    if (done && err) both_cnt++;
  end

  function automatic logic [7:0] hb(int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  function automatic logic [255:0] exp_digest(int n);
    logic [255:0] d = '0;
    for (int i = 0; i < n; i++) d[255 - 8*i -: 8] = hb(i);
    return d;
  endfunction

  task automatic clear_mon();
    load_cnt = 0; first_load = -1; last_load = -1; rd_cnt = 0; last_addr = -1;
    xstart_cnt = 0; xstart_cyc = -1; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    busy_cnt = 0;
    loads.delete();
  endtask

  task automatic run_cmd(input int len);
    cmd_start = 1'b1; cmd_len = 12'(len); acc = cyc;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    for (int i = 0; i < budget && xstart_cnt == 0; i++) @(negedge clk);
    ok = xstart_cnt != 0;
    @(posedge clk); #1;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    for (int i = 0; i < budget && done_cnt == 0 && err_cnt == 0; i++) @(negedge clk);
    ok = done_cnt != 0 || err_cnt != 0;
    @(posedge clk); #1;
  endtask

  task automatic send_hash(input int n, input logic [7:0] hl, input int gap, input int poke_at);
    for (int i = 0; i < n; i++) begin
      x_valid = 1'b1; x_hash = hb(i); x_hash_len = hl; last_vcyc = cyc;
      if (i == poke_at) begin cmd_start = 1'b1; cmd_len = 12'd7; end
      @(posedge clk); #1;
      x_valid = 1'b0; cmd_start = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    n_chk++;
    if ({busy, done, err, mem_rd_en, x_load, x_start} !== 6'b0 || digest !== '0 || digest_len !== 8'd0 ||
        x_msg_len !== 12'd0 || mem_addr !== 12'd0 || x_msg !== 8'd0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b done=%b err=%b rd=%b load=%b start=%b dlen=%0d required all 0",
                         busy, done, err, mem_rd_en, x_load, x_start, digest_len);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_t1_basic();
    bit ok; int bad = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i);
    clear_mon();
    run_cmd(19);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b required 1", busy); end
    wait_start(200, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL t1_start_timeout: no x_start seen required 1"); end
    n_chk++;
    if (x_msg_len !== 12'd19) begin n_fail++; $display("FAIL t1_msg_len: got %0d required 19", x_msg_len); end
    n_chk++;
    if (load_cnt != 19 || last_load - first_load + 1 != 19) begin
      n_fail++; $display("FAIL t1_load_count: got %0d span %0d required 19", load_cnt, last_load - first_load + 1);
    end
    n_chk++;
    if (first_load != acc + 2) begin n_fail++; $display("FAIL t1_first_load: got cyc %0d required %0d", first_load, acc + 2); end
    foreach (loads[i]) if (loads[i] !== 8'(i)) bad++;
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL t1_load_data: got %0d bad bytes required 0", bad); end
    n_chk++;
    if (xstart_cyc - last_load != 6) begin n_fail++; $display("FAIL t1_gap: got %0d required 6", xstart_cyc - last_load); end
    send_hash(32, 8'd32, 0, -1);
    wait_end(50, ok);
    n_chk++;
    if (done_cnt != 1 || err_cnt != 0) begin n_fail++; $display("FAIL t1_done: got done=%0d err=%0d required 1/0", done_cnt, err_cnt); end
    n_chk++;
    if (done_cyc != last_vcyc + 1) begin n_fail++; $display("FAIL t1_done_cyc: got %0d required %0d", done_cyc, last_vcyc + 1); end
    n_chk++;
    if (digest !== exp_digest(32)) begin n_fail++; $display("FAIL t1_digest: got %h required %h", digest, exp_digest(32)); end
    n_chk++;
    if (digest_len !== 8'd32 || busy !== 1'b0 || xstart_cnt != 1) begin
      n_fail++; $display("FAIL t1_final: got dlen=%0d busy=%b starts=%0d required 32/0/1", digest_len, busy, xstart_cnt);
    end
  endtask

  task automatic test_t2_long();
    bit ok; int bad = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i % 256);
    clear_mon();
    run_cmd(1024);
    wait_start(1200, ok);
    n_chk++;
    if (!ok || load_cnt != 1024 || last_load - first_load + 1 != 1024) begin
      n_fail++; $display("FAIL t2_load_count: got %0d required 1024", load_cnt);
    end
    foreach (loads[i]) if (loads[i] !== 8'(i % 256)) bad++;
    n_chk++;
    if (bad != 0 || loads.size() < 258 || loads[255] !== 8'hFF || loads[256] !== 8'h00) begin
      n_fail++; $display("FAIL t2_load_data: got %0d bad bytes required 0", bad);
    end
    n_chk++;
    if (last_addr != 1023 || rd_cnt != 1024) begin
      n_fail++; $display("FAIL t2_addr: got last=%0d reads=%0d required 1023/1024", last_addr, rd_cnt);
    end
    send_hash(32, 8'd0, 0, -1);
    wait_end(50, ok);
    n_chk++;
    if (xstart_cnt != 1 || done_cnt != 1 || digest_len !== 8'd32 || digest !== exp_digest(32)) begin
      n_fail++; $display("FAIL t2_hash_len0: got starts=%0d done=%0d dlen=%0d required 1/1/32", xstart_cnt, done_cnt, digest_len);
    end
  endtask

  task automatic test_t3_zero_len();
    clear_mon();
    run_cmd(0);
    repeat (4) begin @(posedge clk); #1; end
    n_chk++;
    if (err_cnt != 1 || err_cyc != acc + 1) begin
      n_fail++; $display("FAIL t3_err: got count=%0d cyc=%0d required 1/%0d", err_cnt, err_cyc, acc + 1);
    end
    n_chk++;
    if (busy_cnt != 0 || rd_cnt != 0 || load_cnt != 0) begin
      n_fail++; $display("FAIL t3_quiet: got busy=%0d reads=%0d loads=%0d required 0", busy_cnt, rd_cnt, load_cnt);
    end
    n_chk++;
    if (digest_len !== 8'd32) begin n_fail++; $display("FAIL t3_digest_held: got %0d required 32", digest_len); end
  endtask

  task automatic test_t4_timeout();
    bit ok;
    clear_mon();
    run_cmd(3);
    wait_start(100, ok);
    wait_end(1100, ok);
    n_chk++;
    if (!ok || err_cnt != 1 || done_cnt != 0) begin
      n_fail++; $display("FAIL t4_err: got err=%0d done=%0d required 1/0", err_cnt, done_cnt);
    end
    n_chk++;
    if (err_cyc - xstart_cyc != 1000) begin n_fail++; $display("FAIL t4_latency: got %0d required 1000", err_cyc - xstart_cyc); end
    n_chk++;
    if (busy !== 1'b0 || digest_len !== 8'd0) begin
      n_fail++; $display("FAIL t4_final: got busy=%b dlen=%0d required 0/0", busy, digest_len);
    end
  endtask

  task automatic test_t5_repulse();
    bit ok;
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i);
    clear_mon();
    run_cmd(19);
    repeat (5) begin @(posedge clk); #1; end
    run_cmd(7);
    wait_start(200, ok);
    n_chk++;
    if (load_cnt != 19 || rd_cnt != 19 || x_msg_len !== 12'd19) begin
      n_fail++; $display("FAIL t5_load_count: got %0d len=%0d required 19", load_cnt, x_msg_len);
    end
    send_hash(32, 8'd200, 2, 10);
    wait_end(50, ok);
    n_chk++;
    if (done_cnt != 1 || xstart_cnt != 1 || digest !== exp_digest(32) || digest_len !== 8'd32) begin
      n_fail++; $display("FAIL t5_digest: got done=%0d dlen=%0d %h required 1/32 %h", done_cnt, digest_len, digest, exp_digest(32));
    end
    repeat (3) begin @(posedge clk); #1; end
    n_chk++;
    if (busy !== 1'b0 || rd_cnt != 19) begin n_fail++; $display("FAIL t5_idle: got busy=%b reads=%0d required 0/19", busy, rd_cnt); end
  endtask

  task automatic test_short_hash();
    bit ok;
    clear_mon();
    run_cmd(4);
    wait_start(100, ok);
    send_hash(20, 8'd20, 0, -1);
    wait_end(50, ok);
    n_chk++;
    if (done_cnt != 1 || digest_len !== 8'd20 || digest !== exp_digest(20)) begin
      n_fail++; $display("FAIL short_hash: got dlen=%0d %h required 20 %h", digest_len, digest, exp_digest(20));
    end
  endtask

  task automatic test_t6_async_reset();
    bit ok;
    clear_mon();
    run_cmd(100);
    for (int i = 0; i < 200 && load_cnt < 10; i++) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    n_chk++;
    if ({busy, mem_rd_en, x_load, x_start} !== 4'b0 || mem_addr !== 12'd0 || x_msg_len !== 12'd0 ||
        x_msg !== 8'd0 || digest !== '0 || digest_len !== 8'd0) begin
      n_fail++; $display("FAIL t6_async: got busy=%b rd=%b load=%b len=%0d required 0", busy, mem_rd_en, x_load, x_msg_len);
    end
    @(posedge clk); #3 resetn = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    run_cmd(5);
    wait_start(100, ok);
    n_chk++;
    if (!ok || load_cnt != 5 || loads.size() != 5 || loads[4] !== 8'd4) begin
      n_fail++; $display("FAIL t6_reload: got %0d loads required 5", load_cnt);
    end
    send_hash(32, 8'd32, 0, -1);
    wait_end(50, ok);
    n_chk++;
    if (done_cnt != 1 || digest !== exp_digest(32)) begin
      n_fail++; $display("FAIL t6_digest: got done=%0d %h required 1 %h", done_cnt, digest, exp_digest(32));
    end
  endtask

  initial begin
    clear_mon();
    #1;
    test_reset();
    test_t1_basic();
    test_t2_long();
    test_t3_zero_len();
    test_t4_timeout();
    test_t5_repulse();
    test_short_hash();
    test_t6_async_reset();
    n_chk++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL done_err_overlap: got %0d required 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
